// File: rtl/sftb_pkg.sv
// sftb_pkg: shared states and constants for the sample scheduler
package sftb_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;
  localparam int SFTB_DATA_W = 32;
  localparam logic [SFTB_DATA_W-1:0] SFTB_SILENCE = '0;
endpackage

// File: rtl/sftb_sample_fifo.sv
// sftb_sample_fifo: power-of-2 synchronous FIFO with flush and occupancy output
module sftb_sample_fifo
  import sftb_pkg::*;
#(
  parameter int DATA_W = SFTB_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                     c,
  input  logic                     r_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_q];
  always_ff @(posedge c or negedge r_n)
    if (!r_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      level <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      level <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge c)
    if (do_push && !flush) mem[wr_q] <= din;
endmodule

// File: rtl/sftb_sample_scheduler.sv
// sftb_sample_scheduler: prefetches samples over req/ack and emits one per divided tick.
// SFTB_UNDERRUN_HOLD_EN: hold the previous sample on underrun instead of emitting silence.
module sftb_sample_scheduler
  import sftb_pkg::*;
#(
  parameter int DATA_W  = SFTB_DATA_W,
  parameter int DEPTH   = 8,
  parameter int PREFILL = 4,
  parameter int DIV_W   = 16
) (
  input  logic                   c,
  input  logic                   r_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [DIV_W-1:0]       div,
  output logic                   fetch_req,
  input  logic                   fetch_ack,
  input  logic [DATA_W-1:0]      fetch_data,
  input  logic                   fetch_eof,
  output logic [DATA_W-1:0]      x,
  output logic                   x_valid,
  output logic                   busy,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level
);
  localparam int LW = $clog2(DEPTH) + 1;
  state_t state_q, state_d;
  logic [DIV_W-1:0] div_q, cnt_q;
  logic [DATA_W-1:0] head;
  logic [LW-1:0] level_d;
  logic eof_q, eof_d, ack_v, active, push, pop, flush, tick, done, req_d, full, empty;
  sftb_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .c(c), .r_n(r_n), .push(push), .pop(pop), .flush(flush), .din(fetch_data),
    .dout(head), .full(full), .empty(empty), .level(level)
  );
  assign busy = state_q != IDLE;
  always_comb begin
    ack_v   = fetch_req && fetch_ack;
    active  = state_q == FILL || state_q == RUN;
    done    = state_q == RUN && empty && eof_q;
    tick    = state_q == RUN && !stop && !done && cnt_q == div_q;
    pop     = tick && !empty;
    push    = active && !stop && ack_v && !fetch_eof && (!full || pop);
    eof_d   = eof_q || (active && ack_v && fetch_eof);
    flush   = state_q == DRAIN && (!fetch_req || ack_v);
    level_d = flush ? '0 : level + LW'(push) - LW'(pop);
    // a pending request must survive into DRAIN so its ack can be absorbed
    req_d   = (fetch_req && !ack_v) || (active && !stop && !eof_d && level_d < LW'(DEPTH));
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? FILL : IDLE;
      FILL:    state_d = stop ? DRAIN : (eof_q && empty) ? IDLE
                       : (level >= LW'(PREFILL) || eof_q) ? RUN : FILL;
      RUN:     state_d = stop ? DRAIN : done ? IDLE : RUN;
      DRAIN:   state_d = flush ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge c or negedge r_n)
    if (!r_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      eof_q     <= 1'b0;
      fetch_req <= 1'b0;
      x         <= '0;
      x_valid   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetch_req <= req_d;
      x_valid   <= tick;
      cnt_q     <= (state_q == RUN && !stop) ? (cnt_q == div_q ? '0 : cnt_q + 1'b1) : '0;
      if (state_q == IDLE && start) begin
        div_q    <= div;
        eof_q    <= 1'b0;
        underrun <= 1'b0;
      end else begin
        eof_q <= eof_d;
        if (tick && empty) underrun <= 1'b1;
      end
`ifdef SFTB_UNDERRUN_HOLD_EN
      if (pop) x <= head;
`else
      if (tick) x <= pop ? head : DATA_W'(SFTB_SILENCE);
`endif
    end
endmodule

// File: tb/tb_sftb_sample_scheduler.sv
// tb_sftb_sample_scheduler: directed scoreboard bench with a req/ack source model
module tb_sftb_sample_scheduler;
  localparam int DEPTH = 8;
  localparam int PREFILL = 4;
  logic c = 1'b0, r_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic fetch_ack = 1'b0, fetch_eof = 1'b0;
  logic [15:0] div = '0;
  logic [31:0] fetch_data = '0, x;
  logic fetch_req, x_valid, busy, underrun;
  logic [3:0] level;
  sftb_sample_scheduler #(.DATA_W(32), .DEPTH(DEPTH), .PREFILL(PREFILL), .DIV_W(16)) dut (
    .c(c), .r_n(r_n), .start(start), .stop(stop), .div(div),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack), .fetch_data(fetch_data), .fetch_eof(fetch_eof),
    .x(x), .x_valid(x_valid), .busy(busy), .underrun(underrun), .level(level)
  );
  always #5 c = ~c;
  int tests = 0, fails = 0;
  int cyc = 0, nstrobe = 0, run_strobes = 0, last_cyc = 0, run_acks = 0;
  int src_delay = 0, eof_at = 0, wait_cnt = 0, given = 0, exp_period = 4, max_level = 0;
  logic [31:0] next_data = 32'd1, inflight = '0, last_x = '0, exp_x;
  logic inflight_v = 1'b0, inflight_eof = 1'b0, full_chk = 1'b0;
  logic [31:0] sbq[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // monitor first, then source: an item acked this edge cannot appear on x yet
  always @(negedge c) begin
    cyc++;
    if (!r_n) begin
      sbq.delete();
      fetch_ack = 1'b0;
      fetch_eof = 1'b0;
      inflight_v = 1'b0;
      wait_cnt = 0;
      last_x = '0;
      run_strobes = 0;
      run_acks = 0;
    end else begin
      if (x_valid) begin
`ifdef SFTB_UNDERRUN_HOLD_EN
        exp_x = sbq.size() > 0 ? sbq.pop_front() : last_x;
`else
        exp_x = sbq.size() > 0 ? sbq.pop_front() : 32'd0;
`endif
        chk("x", x, exp_x);
        if (run_strobes > 0) chk("period", 32'(cyc - last_cyc), 32'(exp_period));
        else chk("prefill", 32'(run_acks >= PREFILL), 32'd1);
        last_x = exp_x;
        nstrobe++;
        run_strobes++;
        last_cyc = cyc;
      end
      if (full_chk) begin
        if (int'(level) > max_level) max_level = int'(level);
        if (int'(level) >= DEPTH) chk("req_at_full", 32'(fetch_req), 32'd0);
      end
      if (!busy) begin
        run_strobes = 0;
        run_acks = 0;
      end
      if (fetch_ack) begin
        fetch_ack = 1'b0;
        fetch_eof = 1'b0;
        if (inflight_v && !inflight_eof) begin
          sbq.push_back(inflight);
          run_acks++;
        end
        inflight_v = 1'b0;
      end else if (fetch_req) begin
        if (wait_cnt >= src_delay) begin
          wait_cnt = 0;
          fetch_ack = 1'b1;
          inflight_v = 1'b1;
          if (eof_at != 0 && given == eof_at) begin
            fetch_eof = 1'b1;
            inflight_eof = 1'b1;
            fetch_data = 32'hDEADBEEF;
          end else begin
            fetch_eof = 1'b0;
            inflight_eof = 1'b0;
            fetch_data = next_data;
            inflight = next_data;
            next_data++;
            given++;
          end
        end else wait_cnt++;
      end
      if (!busy && !fetch_ack) sbq.delete();
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge c);
    #1;
  endtask
  task automatic pulse_start(input int d);
    div = 16'(d);
    exp_period = d + 1;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask
  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask
  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while (busy && k < bound) begin
      step(1);
      k++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask
  task automatic wait_strobes(input int n, input int bound);
    int base = nstrobe;
    int k = 0;
    while (nstrobe < base + n && k < bound) begin
      step(1);
      k++;
    end
    chk("strobe_wait", 32'(nstrobe >= base + n), 32'd1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req"}, 32'(fetch_req), 32'd0);
    chk({tag, "_xv"}, 32'(x_valid), 32'd0);
    chk({tag, "_x"}, x, 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
  endtask
  initial begin
    int nb, k;
    step(2);
    chk_zero("reset");
    r_n = 1'b1;
    step(2);
    src_delay = 0;
    pulse_start(3);
    chk("busy_start", 32'(busy), 32'd1);
    wait_strobes(6, 300);
    chk("prefill_underrun", 32'(underrun), 32'd0);
    pulse_stop();
    nb = nstrobe;
    wait_idle("prefill_idle", 50);
    chk("prefill_level", 32'(level), 32'd0);
    chk("prefill_no_strobe", 32'(nstrobe), 32'(nb));
    eof_at = given + 5;
    nb = nstrobe;
    pulse_start(3);
    wait_idle("eof_idle", 400);
    chk("eof_strobes", 32'(nstrobe - nb), 32'd5);
    chk("eof_underrun", 32'(underrun), 32'd0);
    chk("eof_level", 32'(level), 32'd0);
    step(10);
    chk("eof_no_req", 32'(fetch_req), 32'd0);
    eof_at = 0;
    src_delay = 3;
    pulse_start(0);
    step(60);
    chk("underrun_set", 32'(underrun), 32'd1);
    pulse_stop();
    wait_idle("underrun_idle", 50);
    chk("underrun_sticky", 32'(underrun), 32'd1);
    pulse_start(3);
    k = 0;
    while (!(fetch_req && wait_cnt == 1) && k < 100) begin
      step(1);
      k++;
    end
    chk("stop_req_seen", 32'(k < 100), 32'd1);
    pulse_stop();
    chk("stop_req_held", 32'(fetch_req), 32'd1);
    chk("stop_drain_busy", 32'(busy), 32'd1);
    nb = nstrobe;
    wait_idle("stop_idle", 50);
    chk("stop_req_low", 32'(fetch_req), 32'd0);
    chk("stop_level", 32'(level), 32'd0);
    chk("stop_no_strobe", 32'(nstrobe), 32'(nb));
    src_delay = 0;
    full_chk = 1'b1;
    pulse_start(15);
    chk("full_underrun_clr", 32'(underrun), 32'd0);
    step(120);
    chk("full_max_level", 32'(max_level), 32'(DEPTH));
    full_chk = 1'b0;
    #3;
    r_n = 1'b0;
    #1;
    chk_zero("async_reset");
    step(2);
    r_n = 1'b1;
    step(1);
    pulse_start(3);
    wait_strobes(3, 200);
    chk("fresh_underrun", 32'(underrun), 32'd0);
    pulse_stop();
    wait_idle("fresh_idle", 50);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
